// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller: light codes and the
// debounce counter sizing used by the sensor front end.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam int DEBOUNCE_DEFAULT = 4;

  // Counter must be able to hold values 0..DEBOUNCE.
  function automatic int db_cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

  localparam int DB_CNT_W = $clog2(DEBOUNCE_DEFAULT + 1);

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus enable-gated debounce for one loop sensor;
// emits a pulse when the accepted level rises.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sense,
  output logic rise
);

  localparam int CNT_W = db_cnt_width(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             db_r;
  logic             db_nxt_s;
  logic             rise_r;
  logic             rise_nxt_s;

  // Synchronizer runs every cycle, independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sense;
      sync2_r <= sync1_r;
    end
  end

  // The level flips on the DEBOUNCE-th consecutive differing cycle. A rise
  // pulse is held while enable is low so the parent never misses it.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    db_nxt_s   = db_r;
    rise_nxt_s = rise_r;
    if (enable) begin
      rise_nxt_s = 1'b0;
      if (sync2_r != db_r) begin
        if (cnt_r == CNT_LAST) begin
          db_nxt_s   = sync2_r;
          cnt_nxt_s  = '0;
          rise_nxt_s = sync2_r;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s = '0;
      end
    end else begin
      cnt_nxt_s  = cnt_r;
      db_nxt_s   = db_r;
      rise_nxt_s = rise_r;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= '0;
      db_r   <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      db_r   <= db_nxt_s;
      rise_r <= rise_nxt_s;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Turns the road 2/4 loop sensors into latched vehicle requests and
// saturating arrival counts, both cleared when the side road is green.
module car_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sense2,
  input  logic              sense4,
  input  logic [1:0]        l24,
  output logic              car2,
  output logic              car4,
  output logic [WAIT_W-1:0] wait2,
  output logic [WAIT_W-1:0] wait4
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  logic              rise2_s;
  logic              rise4_s;
  logic              served_s;
  logic              arrive2_s;
  logic              arrive4_s;
  logic              car2_nxt_s;
  logic              car4_nxt_s;
  logic [WAIT_W-1:0] wait2_nxt_s;
  logic [WAIT_W-1:0] wait4_nxt_s;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db2 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sense  (sense2),
    .rise   (rise2_s)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db4 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sense  (sense4),
    .rise   (rise4_s)
  );

  // Unused code 2'b11 is deliberately treated as not served.
  assign served_s  = (l24 == GREEN);
  assign arrive2_s = rise2_s & enable;
  assign arrive4_s = rise4_s & enable;

  // Green wins over a simultaneous arrival: the car proceeds on green.
  always_comb begin
    car2_nxt_s  = car2;
    car4_nxt_s  = car4;
    wait2_nxt_s = wait2;
    wait4_nxt_s = wait4;
    if (served_s) begin
      car2_nxt_s  = 1'b0;
      car4_nxt_s  = 1'b0;
      wait2_nxt_s = '0;
      wait4_nxt_s = '0;
    end else begin
      if (arrive2_s) begin
        car2_nxt_s = 1'b1;
        if (wait2 != WAIT_MAX) begin
          wait2_nxt_s = wait2 + WAIT_W'(1);
        end else begin
          wait2_nxt_s = wait2;
        end
      end else begin
        car2_nxt_s  = car2;
        wait2_nxt_s = wait2;
      end
      if (arrive4_s) begin
        car4_nxt_s = 1'b1;
        if (wait4 != WAIT_MAX) begin
          wait4_nxt_s = wait4 + WAIT_W'(1);
        end else begin
          wait4_nxt_s = wait4;
        end
      end else begin
        car4_nxt_s  = car4;
        wait4_nxt_s = wait4;
      end
    end
  end

  // Request latches and arrival counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car2  <= 1'b0;
      car4  <= 1'b0;
      wait2 <= '0;
      wait4 <= '0;
    end else begin
      car2  <= car2_nxt_s;
      car4  <= car4_nxt_s;
      wait2 <= wait2_nxt_s;
      wait4 <= wait4_nxt_s;
    end
  end

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural per-road model.
module tb_car_sensor_conditioner;
  import traffic_pkg::*;

  localparam int D    = 4;
  localparam int WW   = 4;
  localparam int WMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          sense2 = 1'b0;
  logic          sense4 = 1'b0;
  logic [1:0]    l24 = 2'b00;
  logic          car2;
  logic          car4;
  logic [WW-1:0] wait2;
  logic [WW-1:0] wait4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  car_sensor_conditioner #(.DEBOUNCE(D), .WAIT_W(WW)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sense2 (sense2),
    .sense4 (sense4),
    .l24    (l24),
    .car2   (car2),
    .car4   (car4),
    .wait2  (wait2),
    .wait4  (wait4)
  );

  // Behavioural road model: raw sample seen two edges later, level accepted
  // after D differing enabled cycles, arrival applied on the following edge.
  typedef struct {
    bit d1;
    bit d2;
    bit db;
    bit pend;
    bit car;
    int run;
    int waitc;
  } road_t;

  road_t m_road[2];

  function automatic road_t zero_road();
    road_t r;
    r.d1 = 0; r.d2 = 0; r.db = 0; r.pend = 0; r.car = 0; r.run = 0; r.waitc = 0;
    return r;
  endfunction

  function automatic road_t step_road(road_t r, bit raw, bit en, bit served);
    road_t n;
    n = r;
    if (served) begin
      n.car = 0;
      n.waitc = 0;
    end else if (r.pend && en) begin
      n.car = 1;
      n.waitc = (r.waitc + 1 > WMAX) ? WMAX : r.waitc + 1;
    end
    if (en) begin
      n.pend = 0;
      if (r.d2 != r.db) begin
        n.run = r.run + 1;
        if (n.run >= D) begin
          n.db = r.d2;
          n.run = 0;
          n.pend = r.d2;
        end
      end else begin
        n.run = 0;
      end
    end
    n.d2 = r.d1;
    n.d1 = raw;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_road[0] <= zero_road();
      m_road[1] <= zero_road();
    end else begin
      m_road[0] <= step_road(m_road[0], sense2, enable, l24 == GREEN);
      m_road[1] <= step_road(m_road[1], sense4, enable, l24 == GREEN);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; sense2 = 1'b0; sense4 = 1'b0; l24 = RED;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; sense2 = 1'b1; sense4 = 1'b1;
    #1;
    checks++;
    if ({car2, car4, wait2, wait4} !== 10'd0) begin
      fails++;
      $display("FAIL reset_state: got %b, want 0", {car2, car4, wait2, wait4});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({car2, car4, wait2, wait4} !== 10'd0) begin
      fails++;
      $display("FAIL reset_hold: got %b, want 0", {car2, car4, wait2, wait4});
    end
    reset = 1'b0; sense2 = 1'b0; sense4 = 1'b0; enable = 1'b0;
  endtask

  task automatic test_clean_arrival();
    logic exp;
    do_reset();
    enable = 1'b1; l24 = RED;
    @(negedge clk);
    sense2 = 1'b1;
    for (int i = 0; i <= D + 3; i++) begin
      @(negedge clk);
      exp = (i >= D + 2);
      checks++;
      if (car2 !== exp) begin
        fails++;
        $display("FAIL clean_latency edge k+%0d: car2=%b want %b", i, car2, exp);
      end
    end
    checks++;
    if (wait2 !== 4'd1 || car4 !== 1'b0 || wait4 !== 4'd0) begin
      fails++;
      $display("FAIL clean_counts: wait2=%0d car4=%b wait4=%0d want 1 0 0", wait2, car4, wait4);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1'b1; l24 = RED;
    @(negedge clk);
    sense4 = 1'b1;
    repeat (D - 1) @(negedge clk);
    sense4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (car4 !== 1'b0 || wait4 !== 4'd0) begin
        fails++;
        $display("FAIL glitch_reject cyc %0d: car4=%b wait4=%0d want 0 0", i, car4, wait4);
      end
    end
    sense4 = 1'b1;
    repeat (D) @(negedge clk);
    sense4 = 1'b0;
    repeat (D + 4) @(negedge clk);
    checks++;
    if (car4 !== 1'b1 || wait4 !== 4'd1) begin
      fails++;
      $display("FAIL glitch_min_pulse: car4=%b wait4=%0d want 1 1", car4, wait4);
    end
  endtask

  task automatic test_serve_clear();
    do_reset();
    enable = 1'b1; l24 = RED;
    for (int n = 0; n < 3; n++) begin
      sense2 = 1'b1;
      repeat (D + 3) @(negedge clk);
      sense2 = 1'b0;
      repeat (D + 3) @(negedge clk);
    end
    checks++;
    if (car2 !== 1'b1 || wait2 !== 4'd3) begin
      fails++;
      $display("FAIL serve_setup: car2=%b wait2=%0d want 1 3", car2, wait2);
    end
    l24 = GREEN;
    @(negedge clk);
    checks++;
    if (car2 !== 1'b0 || wait2 !== 4'd0) begin
      fails++;
      $display("FAIL serve_clear: car2=%b wait2=%0d want 0 0", car2, wait2);
    end
    sense2 = 1'b1;
    repeat (D + 6) @(negedge clk);
    checks++;
    if (car2 !== 1'b0 || wait2 !== 4'd0) begin
      fails++;
      $display("FAIL arrive_on_green: car2=%b wait2=%0d want 0 0", car2, wait2);
    end
    sense2 = 1'b0;
    repeat (D + 3) @(negedge clk);
    l24 = RED;
    repeat (4) @(negedge clk);
    checks++;
    if (car2 !== 1'b0 || car4 !== 1'b0) begin
      fails++;
      $display("FAIL after_green: car2=%b car4=%b want 0 0", car2, car4);
    end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    enable = 1'b1; l24 = RED;
    for (int n = 1; n <= 20; n++) begin
      sense4 = 1'b1;
      repeat (D + 3) @(negedge clk);
      sense4 = 1'b0;
      repeat (D + 3) @(negedge clk);
      exp = (n > WMAX) ? WMAX : n;
      checks++;
      if (int'(wait4) != exp || car4 !== 1'b1) begin
        fails++;
        $display("FAIL saturation n=%0d: wait4=%0d car4=%b want %0d 1", n, wait4, car4, exp);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic exp;
    do_reset();
    enable = 1'b0; l24 = RED; sense2 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (car2 !== 1'b0) begin
      fails++;
      $display("FAIL freeze_hold: car2=%b want 0", car2);
    end
    enable = 1'b1;
    for (int i = 0; i <= D + 1; i++) begin
      @(negedge clk);
      exp = (i >= D);
      checks++;
      if (car2 !== exp) begin
        fails++;
        $display("FAIL enable_latency edge e+%0d: car2=%b want %b", i, car2, exp);
      end
    end
    enable = 1'b0; l24 = GREEN;
    @(negedge clk);
    checks++;
    if (car2 !== 1'b0 || wait2 !== 4'd0) begin
      fails++;
      $display("FAIL serve_while_disabled: car2=%b wait2=%0d want 0 0", car2, wait2);
    end
    enable = 1'b1;
    @(negedge clk);
    l24 = RED;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (car2 !== 1'b0 || wait2 !== 4'd0) begin
        fails++;
        $display("FAIL parked_no_rerequest cyc %0d: car2=%b wait2=%0d want 0 0", i, car2, wait2);
      end
    end
    sense2 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic exp;
    do_reset();
    enable = 1'b1; l24 = RED;
    sense2 = 1'b1;
    repeat (D + 3) @(negedge clk);
    sense2 = 1'b0;
    repeat (D + 3) @(negedge clk);
    sense2 = 1'b1;
    repeat (D + 3) @(negedge clk);
    checks++;
    if (car2 !== 1'b1 || wait2 !== 4'd2) begin
      fails++;
      $display("FAIL async_setup: car2=%b wait2=%0d want 1 2", car2, wait2);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({car2, car4, wait2, wait4} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset_immediate: got %b want 0", {car2, car4, wait2, wait4});
    end
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i <= D + 3; i++) begin
      @(negedge clk);
      exp = (i >= D + 2);
      checks++;
      if (car2 !== exp) begin
        fails++;
        $display("FAIL async_rearm edge k+%0d: car2=%b want %b", i, car2, exp);
      end
    end
    sense2 = 1'b0;
  endtask

  task automatic test_random();
    int hold2 = 0;
    int hold4 = 0;
    int holdl = 0;
    int r;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (car2 !== m_road[0].car) begin
        fails++;
        $display("FAIL rand_car2 cyc %0d: got %b want %b", c, car2, m_road[0].car);
      end
      checks++;
      if (car4 !== m_road[1].car) begin
        fails++;
        $display("FAIL rand_car4 cyc %0d: got %b want %b", c, car4, m_road[1].car);
      end
      checks++;
      if (wait2 !== m_road[0].waitc[3:0]) begin
        fails++;
        $display("FAIL rand_wait2 cyc %0d: got %0d want %0d", c, wait2, m_road[0].waitc);
      end
      checks++;
      if (wait4 !== m_road[1].waitc[3:0]) begin
        fails++;
        $display("FAIL rand_wait4 cyc %0d: got %0d want %0d", c, wait4, m_road[1].waitc);
      end
      if (hold2 == 0) begin
        sense2 = ~sense2;
        hold2 = $urandom_range(1, 9);
      end else begin
        hold2--;
      end
      if (hold4 == 0) begin
        sense4 = ~sense4;
        hold4 = $urandom_range(1, 9);
      end else begin
        hold4--;
      end
      enable = ($urandom_range(0, 9) != 0);
      if (holdl == 0) begin
        r = $urandom_range(0, 9);
        l24 = (r < 6) ? RED : (r < 7) ? YELLOW : (r < 9) ? GREEN : 2'b11;
        holdl = $urandom_range(3, 25);
      end else begin
        holdl--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_arrival();
    test_glitch();
    test_serve_clear();
    test_saturation();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
Upstream stage of the traffic controller. Conditions the raw inductive-loop sensors on side roads 2 and 4 into clean, latched vehicle requests, car2 and car4. These feed the light FSM's request input (car2|car4). A request is held until the side road (light24) is served green. A per-road saturating arrival count is also produced for status and debug.

Parameters:
DEBOUNCE, 4, consecutive synchronized cycles a sensor level must hold before it is accepted (legal values ≥1)
WAIT_W, 4, width of each per-road arrival counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  global advance enable, same signal that drives the timer
sense2  input  1  raw loop sensor, road 2; asynchronous and may bounce
sense4  input  1  raw loop sensor, road 4; asynchronous and may bounce
l24  input  2  current light code for roads 2/4, from the light FSM
car2  output  1  latched vehicle request, road 2
car4  output  1  latched vehicle request, road 4
wait2  output  WAIT_W  arrivals on road 2 since last served, saturating
wait4  output  WAIT_W  arrivals on road 4 since last served, saturating

Behaviour:
- Reset (asynchronous, active-high): all synchronizer flops, debounce counters, debounced levels, car2, car4, wait2 and wait4 go to 0.
- Synchronizer: each senseN passes through a 2-flop synchronizer. These flops run every cycle, regardless of enable.
- Debounce, per road, gated by enable:
  - The debounced level db starts at 0.
  - When the synchronized value differs from db, a counter increments.
  - When the counter reaches DEBOUNCE and the value still differs, db takes the new value and the counter clears.
  - Any cycle where the synchronized value equals db clears the counter.
  - A pulse that lasts DEBOUNCE-1 or fewer synchronized cycles never changes db.
- Arrival event: a 0→1 transition of db, with enable high.
- Served: l24 equals GREEN.
- Request latch, carN:
  - Set on an arrival event when the road is not served.
  - Cleared on any cycle in which the road is served.
  - Arrival and served in the same cycle: the latch clears. The car proceeds on green.
  - Otherwise the latch holds.
- Arrival count, waitN:
  - Increments by 1 on each arrival event when the road is not served.
  - Saturates at 2^WAIT_W-1 with no wrap.
  - Clears to 0 on any served cycle, regardless of enable.
- Latency: raw senseN first sampled high at edge k and held → carN is 1 after edge k+DEBOUNCE+2.
- enable low: debounce counters, db, carN and waitN all hold, with no arrivals detected. Exception: the served-clear still applies.
- A sensor held high across green (car parked on loop) generates no new arrival after green ends. The driver must leave and re-arrive.
- Both roads are served by the same light code, l24. Both latches clear together.
- Light codes other than GREEN, including the unused code, count as not served.

Decomposition:
- Shared package traffic_pkg holds:
  - the light-code constants RED=2'b00, YELLOW=2'b01, GREEN=2'b10;
  - a localparam for the debounce counter width, $clog2(DEBOUNCE+1).
- The light FSM and timer use the same package.
- One sub-module, sensor_debounce, contains the synchronizer, the debounce counter and db with its rise-pulse output. It is instantiated twice. The latch and counter logic stays in the parent.

Test Plan:
- Clean arrival: with DEBOUNCE=4, enable=1, l24=RED, sense2 goes high before edge 10 and holds → car2=1 after edge 16, wait2=1; car4 stays 0.
- Glitch reject: sense4 high for exactly 3 synchronized cycles, then low → car4=0 and wait4=0 for 20 cycles. A subsequent 4-cycle pulse → car4=1.
- Serve clear: car2=1 and wait2=3, then l24=GREEN for one cycle → car2=0 and wait2=0 after that edge. A car arriving during green → car2 stays 0.
- Saturation: 20 separate clean arrivals on road 4 with l24=RED and WAIT_W=4 → wait4 climbs to 15 and holds at 15; car4 remains 1.
- Enable freeze: enable=0 while sense2 is held high for 10 cycles → car2=0. Raise enable → car2=1 DEBOUNCE+1 cycles later. A parked sensor across green → no re-request after l24 returns to RED.
- Async reset mid-operation: assert reset between edges while car2=1 and wait2=2 → all outputs 0 immediately. Release reset with sense2 still high → car2 re-asserts after DEBOUNCE+2 edges.
